// File: rtl/ringbuffer_seq_pkg.sv
// Shared sizes and FSM state type for the ring-buffer frame sequencer.
// Used by ringbuffer_sequencer and, under RINGBUFFER_SEQ_STATS_EN, ringbuffer_seq_stats.
package ringbuffer_seq_pkg;

    localparam int unsigned RB_WIDTH  = 16;
    localparam int unsigned RB_DEPTH  = 8;
    localparam int unsigned RB_PTR_W  = $clog2(RB_DEPTH);
    localparam int unsigned RB_STAT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LISTEN,
        FILL,
        RD_ADDR,
        RD_DATA
    } rb_seq_state_t;

endpackage

// File: rtl/ringbuffer_seq_stats.sv
// Saturating frame/stall counters for the sequencer.
// Only present when RINGBUFFER_SEQ_STATS_EN is defined.
`ifdef RINGBUFFER_SEQ_STATS_EN
module ringbuffer_seq_stats
    import ringbuffer_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 done_i,
    input  logic                 stall_i,
    output logic [RB_STAT_W-1:0] frame_cnt_o,
    output logic [RB_STAT_W-1:0] stall_cnt_o
);

    logic [RB_STAT_W-1:0] frame_q, frame_d;
    logic [RB_STAT_W-1:0] stall_q, stall_d;

    always_comb begin
        frame_d = frame_q;
        stall_d = stall_q;
        if (done_i && (frame_q != '1)) begin
            frame_d = frame_q + RB_STAT_W'(1);
        end
        if (stall_i && (stall_q != '1)) begin
            stall_d = stall_q + RB_STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q <= '0;
            stall_q <= '0;
        end else begin
            frame_q <= frame_d;
            stall_q <= stall_d;
        end
    end

    assign frame_cnt_o = frame_q;
    assign stall_cnt_o = stall_q;

endmodule
`endif

// File: rtl/ringbuffer_sequencer.sv
// Frame controller for the ring buffer: fills DEPTH words from upstream, then drains them downstream.
// Optional RINGBUFFER_SEQ_STATS_EN adds frame_cnt/stall_cnt outputs.
module ringbuffer_sequencer
    import ringbuffer_seq_pkg::*;
#(
    parameter int unsigned WIDTH = RB_WIDTH,
    parameter int unsigned DEPTH = RB_DEPTH,
    parameter int unsigned PTR_W = RB_PTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             rb_listen,
    output logic             rb_strobe,
    output logic [WIDTH-1:0] rb_din,
    output logic [PTR_W-1:0] rb_read_ptr,
    input  logic [WIDTH-1:0] rb_dout
`ifdef RINGBUFFER_SEQ_STATS_EN
    ,
    output logic [15:0]      frame_cnt,
    output logic [15:0]      stall_cnt
`endif
);

    localparam logic [PTR_W:0]   LAST_FILL = (PTR_W+1)'(DEPTH - 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    rb_seq_state_t    state_q, state_d;
    logic [PTR_W:0]   fill_cnt_q, fill_cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             strobe_q, strobe_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             done_q, done_d;

    logic in_acc, out_acc, last_strobe, last_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fill_cnt_q <= '0;
            ptr_q      <= '0;
            strobe_q   <= 1'b0;
            din_q      <= '0;
            out_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            ptr_q      <= ptr_d;
            strobe_q   <= strobe_d;
            din_q      <= din_d;
            out_data_q <= out_data_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        // abort suppresses both handshakes in the cycle it is seen
        in_acc      = (state_q == FILL) && !strobe_q && in_valid && !abort;
        out_acc     = (state_q == RD_DATA) && out_ready && !abort;
        last_strobe = strobe_q && (fill_cnt_q == LAST_FILL);
        last_word   = (ptr_q == LAST_PTR);

        state_d = state_q;
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start && !abort) state_d = LISTEN;
                LISTEN:  state_d = FILL;
                FILL:    if (last_strobe) state_d = RD_ADDR;
                RD_ADDR: state_d = RD_DATA;
                RD_DATA: if (out_acc) state_d = last_word ? IDLE : RD_ADDR;
                default: state_d = IDLE;
            endcase
        end

        strobe_d = in_acc;
        din_d    = in_acc ? in_data : din_q;

        fill_cnt_d = fill_cnt_q;
        if ((state_q == FILL) && strobe_q) begin
            fill_cnt_d = fill_cnt_q + (PTR_W+1)'(1);
        end
        if (state_d != FILL) begin
            fill_cnt_d = '0;
        end

        ptr_d = ptr_q;
        if (out_acc) begin
            ptr_d = last_word ? '0 : ptr_q + PTR_W'(1);
        end
        if ((state_d == IDLE) || (state_q == FILL)) begin
            ptr_d = '0;
        end

        // rb_dout for index k is sampled at the edge that leaves RD_ADDR
        out_data_d = ((state_q == RD_ADDR) && !abort) ? rb_dout : out_data_q;
        done_d     = out_acc && last_word;
    end

    always_comb begin
        busy        = (state_q != IDLE);
        rb_listen   = (state_q == LISTEN) || (state_q == FILL);
        in_ready    = (state_q == FILL) && !strobe_q;
        out_valid   = (state_q == RD_DATA);
        rb_strobe   = strobe_q;
        rb_din      = din_q;
        rb_read_ptr = ptr_q;
        out_data    = out_data_q;
        done        = done_q;
    end

`ifdef RINGBUFFER_SEQ_STATS_EN
    ringbuffer_seq_stats u_stats (
        .clk        (clk),
        .reset      (reset),
        .done_i     (done_q),
        .stall_i    ((state_q == RD_DATA) && !out_ready),
        .frame_cnt_o(frame_cnt),
        .stall_cnt_o(stall_cnt)
    );
`endif

endmodule

// File: tb/tb_ringbuffer_sequencer.sv
// Self-checking bench for ringbuffer_sequencer with a behavioural ring-buffer and frame model.
// Stats ports are connected and checked only when RINGBUFFER_SEQ_STATS_EN is defined.
module tb_ringbuffer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        rb_listen;
    logic        rb_strobe;
    logic [15:0] rb_din;
    logic [2:0]  rb_read_ptr;
    logic [15:0] rb_dout;
`ifdef RINGBUFFER_SEQ_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ringbuffer_sequencer #(.WIDTH(16), .DEPTH(8), .PTR_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .rb_listen  (rb_listen),
        .rb_strobe  (rb_strobe),
        .rb_din     (rb_din),
        .rb_read_ptr(rb_read_ptr),
        .rb_dout    (rb_dout)
`ifdef RINGBUFFER_SEQ_STATS_EN
        ,
        .frame_cnt  (frame_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    // Ring buffer: write index restarts whenever listen is low; read is combinational.
    logic [15:0] buf_mem [8];
    int unsigned buf_wr = 0;
    always @(posedge clk) begin
        if (!rb_listen) begin
            buf_wr <= 0;
        end else if (rb_strobe) begin
            buf_mem[buf_wr[2:0]] <= rb_din;
            buf_wr <= buf_wr + 1;
        end
    end
    assign rb_dout = buf_mem[rb_read_ptr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame-level reference model, advanced once per cycle from the sampled inputs.
    initial begin : monitor
        bit m_init, m_busy, m_listen1, m_strobe, m_draining, m_dvalid, m_done, done_next;
        bit exp_listen, exp_ready, exp_ovalid;
        int m_fill, m_k, exp_ptr;
        logic [15:0] m_din;
        logic [15:0] m_words[$];
`ifdef RINGBUFFER_SEQ_STATS_EN
        int m_frames, m_stalls;
        m_frames = 0;
        m_stalls = 0;
`endif
        m_init = 0; m_busy = 0; m_listen1 = 0; m_strobe = 0;
        m_draining = 0; m_dvalid = 0; m_done = 0;
        m_fill = 0; m_k = 0; m_din = '0;
        forever begin
            @(negedge clk);
            exp_listen = m_busy && !m_draining;
            exp_ready  = m_busy && !m_draining && !m_listen1 && !m_strobe;
            exp_ovalid = m_draining && m_dvalid;
            exp_ptr    = m_draining ? m_k : 0;
            if (m_init) begin
                check_eq("busy", 32'(busy), 32'(m_busy));
                check_eq("rb_listen", 32'(rb_listen), 32'(exp_listen));
                check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
                check_eq("rb_strobe", 32'(rb_strobe), 32'(m_strobe));
                check_eq("rb_din", 32'(rb_din), 32'(m_din));
                check_eq("out_valid", 32'(out_valid), 32'(exp_ovalid));
                check_eq("rb_read_ptr", 32'(rb_read_ptr), exp_ptr);
                check_eq("done", 32'(done), 32'(m_done));
                if (exp_ovalid)
                    check_eq("out_data", 32'(out_data),
                             (m_k < m_words.size()) ? 32'(m_words[m_k]) : 32'hDEAD_BEEF);
`ifdef RINGBUFFER_SEQ_STATS_EN
                check_eq("frame_cnt", 32'(frame_cnt), m_frames);
                check_eq("stall_cnt", 32'(stall_cnt), m_stalls);
`endif
            end
            if (reset) begin
                m_init = 1; m_busy = 0; m_listen1 = 0; m_strobe = 0;
                m_draining = 0; m_dvalid = 0; m_done = 0;
                m_fill = 0; m_k = 0; m_din = '0;
                m_words.delete();
`ifdef RINGBUFFER_SEQ_STATS_EN
                m_frames = 0;
                m_stalls = 0;
`endif
            end else begin
`ifdef RINGBUFFER_SEQ_STATS_EN
                if (m_done) m_frames++;
                if (exp_ovalid && !out_ready) m_stalls++;
`endif
                done_next = 0;
                if (m_busy && abort) begin
                    m_busy = 0; m_listen1 = 0; m_strobe = 0;
                    m_draining = 0; m_dvalid = 0; m_k = 0; m_fill = 0;
                    m_words.delete();
                end else if (!m_busy) begin
                    if (start && !abort) begin
                        m_busy = 1; m_listen1 = 1; m_fill = 0;
                        m_words.delete();
                    end
                end else if (m_listen1) begin
                    m_listen1 = 0;
                end else if (!m_draining) begin
                    if (m_strobe) begin
                        m_strobe = 0;
                        m_fill++;
                        if (m_fill == 8) begin
                            m_draining = 1; m_k = 0; m_dvalid = 0;
                        end
                    end else if (in_valid) begin
                        m_strobe = 1;
                        m_din = in_data;
                        m_words.push_back(in_data);
                    end
                end else if (!m_dvalid) begin
                    m_dvalid = 1;
                end else if (out_ready) begin
                    if (m_k == 7) begin
                        m_busy = 0; m_draining = 0; m_dvalid = 0; m_k = 0;
                        done_next = 1;
                    end else begin
                        m_k++;
                        m_dvalid = 0;
                    end
                end
                m_done = done_next;
            end
        end
    end

    task automatic run_frame(input int vpct, input int rpct, input bit sparse, input bit stall3,
                             input int abort_at, input int reset_at, input int abort_pct,
                             input bit seq_data, input bit noise_start,
                             output int strobes, output bit done_seen);
        int n = 0;
        int stall_left = 5;
        bit abort_next = 0;
        bit rst_next = 0;
        bit fin = 0;
        strobes = 0;
        done_seen = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            in_valid  = sparse ? (cyc % 4 == 0) : ($urandom_range(99) < vpct);
            in_data   = seq_data ? 16'(16'h1000 + n) : 16'($urandom);
            out_ready = ($urandom_range(99) < rpct);
            if (stall3 && out_valid && rb_read_ptr == 3'd3 && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end
            abort      = abort_next || ($urandom_range(99) < abort_pct);
            abort_next = 0;
            start      = noise_start && busy && ($urandom_range(9) == 0);
            @(negedge clk);
            if (in_valid && in_ready && !abort) n++;
            if (rb_strobe) strobes++;
            if (done) done_seen = 1;
            if (done || !busy) fin = 1;
            if (rb_strobe && strobes == abort_at) abort_next = 1;
            if (rb_strobe && strobes == reset_at) rst_next = 1;
            tick();
            if (rst_next && !fin) begin
                reset = 1'b1; in_valid = 1'b0; abort = 1'b0; start = 1'b0; out_ready = 1'b0;
                repeat (3) tick();
                reset = 1'b0;
                fin = 1;
            end
        end
        check_eq("frame_end", 32'(fin), 1);
        in_valid = 1'b0; abort = 1'b0; start = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
    endtask

    initial begin : drive
        int st;
        bit dn;
        int ab;
`ifdef RINGBUFFER_SEQ_STATS_EN
        logic [15:0] f0, s0;
`endif
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // reset held 3 cycles after the 3rd strobe
        run_frame(100, 100, 0, 0, -1, 3, 0, 1, 0, st, dn);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_ptr", 32'(rb_read_ptr), 0);
        check_eq("rst_listen", 32'(rb_listen), 0);
        check_eq("rst_strobe", 32'(rb_strobe), 0);
        check_eq("rst_in_ready", 32'(in_ready), 0);
        check_eq("rst_rb_din", 32'(rb_din), 0);

        // back-to-back full frame
        run_frame(100, 100, 0, 0, -1, -1, 0, 1, 0, st, dn);
        check_eq("full_strobes", st, 8);
        check_eq("full_done", 32'(dn), 1);

        // 5-cycle stall on word 3
`ifdef RINGBUFFER_SEQ_STATS_EN
        s0 = stall_cnt;
        f0 = frame_cnt;
`endif
        run_frame(100, 100, 0, 1, -1, -1, 0, 1, 0, st, dn);
        check_eq("bp_strobes", st, 8);
        check_eq("bp_done", 32'(dn), 1);
`ifdef RINGBUFFER_SEQ_STATS_EN
        check_eq("bp_stall5", 32'(stall_cnt - s0), 5);
        check_eq("bp_frame1", 32'(frame_cnt - f0), 1);
`endif

        // sparse input
        run_frame(0, 100, 1, 0, -1, -1, 0, 1, 0, st, dn);
        check_eq("sparse_strobes", st, 8);
        check_eq("sparse_done", 32'(dn), 1);

        // abort after 5th strobe, then a clean frame
`ifdef RINGBUFFER_SEQ_STATS_EN
        f0 = frame_cnt;
`endif
        run_frame(100, 100, 0, 0, 5, -1, 0, 1, 0, st, dn);
        check_eq("abort_strobes", st, 5);
        check_eq("abort_no_done", 32'(dn), 0);
        check_eq("abort_idle", 32'(busy), 0);
`ifdef RINGBUFFER_SEQ_STATS_EN
        check_eq("abort_frame0", 32'(frame_cnt - f0), 0);
`endif
        run_frame(100, 100, 0, 0, -1, -1, 0, 1, 0, st, dn);
        check_eq("post_abort_strobes", st, 8);
        check_eq("post_abort_done", 32'(dn), 1);

        // start pulses while busy, then abort+start together in IDLE
        run_frame(70, 70, 0, 0, -1, -1, 0, 0, 1, st, dn);
        check_eq("noise_strobes", st, 8);
        check_eq("noise_done", 32'(dn), 1);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        check_eq("abort_start_idle", 32'(busy), 0);
        check_eq("abort_start_listen", 32'(rb_listen), 0);

        for (int f = 0; f < 30; f++) begin
            ab = ($urandom_range(3) == 0) ? 2 : 0;
            run_frame(int'($urandom_range(100, 20)), int'($urandom_range(100, 20)), 0, 0,
                      -1, -1, ab, 0, 1'($urandom_range(1)), st, dn);
            if (dn) check_eq("rand_strobes", st, 8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (compared %0d, mismatched %0d)", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
